// File: rtl/selector41_pkg.sv
// Shared constants for the selector41 4:1 channel selector: default data width
// and the {iS1,iS0} select encodings.
package selector41_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] SEL_C0 = 2'b00;
    localparam logic [1:0] SEL_C1 = 2'b01;
    localparam logic [1:0] SEL_C2 = 2'b10;
    localparam logic [1:0] SEL_C3 = 2'b11;

endpackage

// File: rtl/selector41_core.sv
// Combinational WIDTH-bit 4:1 multiplexer with a one-hot decode of the select.
// Any select value that is not one of the four legal encodings yields all-zero.
module selector41_core
    import selector41_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] c0,
    input  logic [WIDTH-1:0] c1,
    input  logic [WIDTH-1:0] c2,
    input  logic [WIDTH-1:0] c3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] z,
    output logic [3:0]       onehot
);

    // An X/Z select matches no case item, so the zero defaults are kept.
    always_comb begin
        z      = '0;
        onehot = 4'b0000;
        case (sel)
            SEL_C0: begin
                z      = c0;
                onehot = 4'b0001;
            end
            SEL_C1: begin
                z      = c1;
                onehot = 4'b0010;
            end
            SEL_C2: begin
                z      = c2;
                onehot = 4'b0100;
            end
            SEL_C3: begin
                z      = c3;
                onehot = 4'b1000;
            end
            default: begin
                z      = '0;
                onehot = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/selector41.sv
// selector41 top: wraps selector41_core; defining SELECTOR41_OUTREG_EN adds a
// one-cycle output register with synchronous active-high reset.
module selector41
    import selector41_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic [WIDTH-1:0] iC0,
    input  logic [WIDTH-1:0] iC1,
    input  logic [WIDTH-1:0] iC2,
    input  logic [WIDTH-1:0] iC3,
    input  logic             iS1,
    input  logic             iS0,
    output logic [WIDTH-1:0] oZ,
    output logic [3:0]       oSel
);

    logic [WIDTH-1:0] core_z;
    logic [3:0]       core_onehot;

    selector41_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .c0     (iC0),
        .c1     (iC1),
        .c2     (iC2),
        .c3     (iC3),
        .sel    ({iS1, iS0}),
        .z      (core_z),
        .onehot (core_onehot)
    );

`ifdef SELECTOR41_OUTREG_EN
    logic [WIDTH-1:0] z_d,   z_q;
    logic [3:0]       sel_d, sel_q;

    always_comb begin
        z_d   = core_z;
        sel_d = core_onehot;
    end

    // Reset wins over capture, so a value sampled alongside reset is dropped.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            z_q   <= '0;
            sel_q <= 4'b0000;
        end else begin
            z_q   <= z_d;
            sel_q <= sel_d;
        end
    end

    assign oZ   = z_q;
    assign oSel = sel_q;
`else
    logic unused_clk_rst;
    assign unused_clk_rst = iClk ^ iRst;

    assign oZ   = core_z;
    assign oSel = core_onehot;
`endif

endmodule

// File: tb/tb_selector41.sv
// Self-checking bench for selector41 (WIDTH=4 and WIDTH=8 instances); adapts its
// expectations to SELECTOR41_OUTREG_EN.
module tb_selector41;

`ifdef SELECTOR41_OUTREG_EN
    localparam bit REGISTERED = 1'b1;
`else
    localparam bit REGISTERED = 1'b0;
`endif

    logic       iClk = 1'b0;
    logic       iRst = 1'b1;
    logic [3:0] iC0 = '0, iC1 = '0, iC2 = '0, iC3 = '0;
    logic [7:0] wC0 = '0, wC1 = '0, wC2 = '0, wC3 = '0;
    logic       iS1 = 1'b0, iS0 = 1'b0;
    logic [3:0] oZ4, oSel4;
    logic [7:0] oZ8;
    logic [3:0] oSel8;

    int testsRun    = 0;
    int testsFailed = 0;

    selector41 #(.WIDTH(4)) dut4 (
        .iClk (iClk), .iRst (iRst),
        .iC0  (iC0),  .iC1  (iC1), .iC2 (iC2), .iC3 (iC3),
        .iS1  (iS1),  .iS0  (iS0),
        .oZ   (oZ4),  .oSel (oSel4)
    );

    selector41 #(.WIDTH(8)) dut8 (
        .iClk (iClk), .iRst (iRst),
        .iC0  (wC0),  .iC1  (wC1), .iC2 (wC2), .iC3 (wC3),
        .iS1  (iS1),  .iS0  (iS0),
        .oZ   (oZ8),  .oSel (oSel8)
    );

    always #5 iClk = ~iClk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, wanted completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: pick array element by index; unknown select gives zero.
    function automatic logic [7:0] refZ(input logic [3:0][7:0] ch, input logic [1:0] s);
        if ($isunknown(s)) return 8'h00;
        return ch[s];
    endfunction

    function automatic logic [3:0] refSel(input logic [1:0] s);
        if ($isunknown(s)) return 4'b0000;
        return 4'b0001 << s;
    endfunction

    function automatic logic [3:0][7:0] widen(input logic [3:0][3:0] c);
        logic [3:0][7:0] w;
        for (int i = 0; i < 4; i++) w[i] = {4'h0, c[i]};
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] actZ, input logic [7:0] expZ,
                               input logic [3:0] actSel, input logic [3:0] expSel);
        testsRun++;
        if (actZ !== expZ || actSel !== expSel) begin
            testsFailed++;
            $display("[TB] FAIL %s: got oZ=%h oSel=%b, expected oZ=%h oSel=%b",
                     name, actZ, actSel, expZ, expSel);
        end
    endtask

    // Drive on the falling edge, then return just after the following rising edge.
    task automatic applyStimulus(input logic [3:0][3:0] c, input logic [3:0][7:0] w,
                                 input logic s1v, input logic s0v, input logic rstv);
        @(negedge iClk);
        iC0 = c[0]; iC1 = c[1]; iC2 = c[2]; iC3 = c[3];
        wC0 = w[0]; wC1 = w[1]; wC2 = w[2]; wC3 = w[3];
        iS1 = s1v;  iS0 = s0v;  iRst = rstv;
        @(posedge iClk);
        #1;
    endtask

    typedef struct {
        logic [3:0] c0, c1, c2, c3;
        logic [1:0] s;
        logic [3:0] ez;
        logic [3:0] esel;
    } vec_t;

    vec_t vecs[8];
    logic [3:0][3:0] cv;
    logic [3:0][7:0] wv;
    logic [3:0][7:0] wideData;
    logic [7:0]      wideExp[4];
    logic [1:0]      sv;
    logic            rv;

    initial begin
        vecs[0] = '{4'h1, 4'h2, 4'h4, 4'h8, 2'b11, 4'b1000, 4'b1000};
        vecs[1] = '{4'h1, 4'h2, 4'h4, 4'h8, 2'b10, 4'b0100, 4'b0100};
        vecs[2] = '{4'h1, 4'h2, 4'h4, 4'h8, 2'b01, 4'b0010, 4'b0010};
        vecs[3] = '{4'h1, 4'h2, 4'h4, 4'h8, 2'b00, 4'b0001, 4'b0001};
        vecs[4] = '{4'hF, 4'h2, 4'h4, 4'h8, 2'b01, 4'b0010, 4'b0010};
        vecs[5] = '{4'hF, 4'h2, 4'hF, 4'h8, 2'b01, 4'b0010, 4'b0010};
        vecs[6] = '{4'hF, 4'h2, 4'hF, 4'hF, 2'b01, 4'b0010, 4'b0010};
        vecs[7] = '{4'h0, 4'h2, 4'h0, 4'h0, 2'b01, 4'b0010, 4'b0010};

        wideData   = {8'h00, 8'hFF, 8'h5A, 8'hA5};
        wideExp[0] = 8'hA5; wideExp[1] = 8'h5A; wideExp[2] = 8'hFF; wideExp[3] = 8'h00;

        // Reset state: cleared outputs when registered, live selection otherwise.
        cv = {4'h8, 4'h4, 4'h2, 4'h1};
        applyStimulus(cv, wideData, 1'b1, 1'b0, 1'b1);
        applyStimulus(cv, wideData, 1'b1, 1'b0, 1'b1);
        checkOutput("reset_state", {4'h0, oZ4},
                    REGISTERED ? 8'h00 : 8'h04, oSel4, REGISTERED ? 4'b0000 : 4'b0100);

        // Directed table: one-hot channel sweep and unselected-channel toggling.
        for (int i = 0; i < 8; i++) begin
            cv = {vecs[i].c3, vecs[i].c2, vecs[i].c1, vecs[i].c0};
            applyStimulus(cv, wideData, vecs[i].s[1], vecs[i].s[0], 1'b0);
            checkOutput($sformatf("table_%0d", i), {4'h0, oZ4}, {4'h0, vecs[i].ez},
                        oSel4, vecs[i].esel);
        end

        // X on select LSB must not leak to the outputs.
        cv = {4'h8, 4'h4, 4'h2, 4'h1};
        applyStimulus(cv, wideData, 1'b0, 1'bx, 1'b0);
        checkOutput("x_select", {4'h0, oZ4}, refZ(widen(cv), {iS1, iS0}),
                    oSel4, refSel({iS1, iS0}));
        checkOutput("x_select_w8", oZ8, refZ(wideData, {iS1, iS0}),
                    oSel8, refSel({iS1, iS0}));

        // Select 00 -> 11: same-cycle and next-edge view.
        applyStimulus(cv, wideData, 1'b0, 1'b0, 1'b0);
        checkOutput("sel00_settle", {4'h0, oZ4}, 8'h01, oSel4, 4'b0001);
        @(negedge iClk);
        iS1 = 1'b1; iS0 = 1'b1;
        #1;
        checkOutput("sel11_same_cycle", {4'h0, oZ4}, REGISTERED ? 8'h01 : 8'h08,
                    oSel4, REGISTERED ? 4'b0001 : 4'b1000);
        @(posedge iClk);
        #1;
        checkOutput("sel11_next_edge", {4'h0, oZ4}, 8'h08, oSel4, 4'b1000);

        // Reset mid-stream with new inputs pending, then release.
        cv = {4'h8, 4'h6, 4'h2, 4'h1};
        applyStimulus(cv, wideData, 1'b1, 1'b0, 1'b1);
        checkOutput("mid_reset", {4'h0, oZ4}, REGISTERED ? 8'h00 : 8'h06,
                    oSel4, REGISTERED ? 4'b0000 : 4'b0100);
        applyStimulus(cv, wideData, 1'b1, 1'b0, 1'b0);
        checkOutput("after_release", {4'h0, oZ4}, 8'h06, oSel4, 4'b0100);

        // WIDTH=8 sweep over all selects.
        for (int s = 0; s < 4; s++) begin
            sv = 2'(s);
            applyStimulus(cv, wideData, sv[1], sv[0], 1'b0);
            checkOutput($sformatf("w8_sel%0d", s), oZ8, wideExp[s], oSel8, 4'b0001 << s);
        end

        // Randomized traffic with occasional reset, against the reference model.
        for (int n = 0; n < 200; n++) begin
            for (int k = 0; k < 4; k++) begin
                cv[k] = 4'($urandom);
                wv[k] = 8'($urandom);
            end
            sv = 2'($urandom_range(0, 3));
            rv = ($urandom_range(0, 11) == 0);
            applyStimulus(cv, wv, sv[1], sv[0], rv);
            checkOutput($sformatf("rand4_%0d", n), {4'h0, oZ4},
                        (REGISTERED && rv) ? 8'h00 : refZ(widen(cv), sv),
                        oSel4, (REGISTERED && rv) ? 4'b0000 : refSel(sv));
            checkOutput($sformatf("rand8_%0d", n), oZ8,
                        (REGISTERED && rv) ? 8'h00 : refZ(wv, sv),
                        oSel8, (REGISTERED && rv) ? 4'b0000 : refSel(sv));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
